// File: rtl/banked_scratchpad_if.sv
// Request/response bundle for the banked scratchpad.
// Packed per-port vectors; index [p] selects a requester.
interface banked_scratchpad_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_WID  = 10,
  parameter int D_WID     = 32
);
  logic [NUM_PORTS-1:0]               req_valid;
  logic [NUM_PORTS-1:0]               req_ready;
  logic [NUM_PORTS-1:0]               req_we;
  logic [NUM_PORTS-1:0][ADDR_WID-1:0] req_addr;
  logic [NUM_PORTS-1:0][D_WID-1:0]    req_wdata;
  logic [NUM_PORTS-1:0]               rsp_valid;
  logic [NUM_PORTS-1:0][D_WID-1:0]    rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/banked_scratchpad.sv
// Word-interleaved multi-port scratchpad, per-bank round-robin,
// two-cycle read pipeline and saturating conflict counter.
module banked_scratchpad #(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_WID  = 10,
  parameter int D_WID     = 32,
  parameter int CNT_WID   = 16
) (
  input  logic               clk,
  input  logic               rst,
  banked_scratchpad_if.slave bus,
  output logic [CNT_WID-1:0] conflict_cnt
);
  localparam int BSEL    = $clog2(NUM_BANKS);
  localparam int ROW_WID = ADDR_WID - BSEL;
  localparam int DEPTH   = 1 << ROW_WID;
  localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0]        rr_ptr [NUM_BANKS];
  logic [NUM_BANKS-1:0] gvld;
  logic [NUM_BANKS-1:0] gwe;
  logic [PW-1:0]        gport  [NUM_BANKS];
  logic [ROW_WID-1:0]   grow   [NUM_BANKS];
  logic [D_WID-1:0]     gwdata [NUM_BANKS];

  logic [BSEL-1:0]      pbank  [NUM_PORTS];
  logic [NUM_BANKS-1:0] hit    [NUM_PORTS];
  logic [NUM_PORTS-1:0] ready;
  logic                 stall;

  logic [D_WID-1:0]     mem    [NUM_BANKS][DEPTH];
  logic [D_WID-1:0]     rdq    [NUM_BANKS];
  logic [NUM_PORTS-1:0] s1_vld;
  logic [BSEL-1:0]      s1_bank [NUM_PORTS];
  logic [NUM_PORTS-1:0]            rsp_vld_q;
  logic [NUM_PORTS-1:0][D_WID-1:0] rsp_dat_q;
  logic [CNT_WID-1:0]   cnt_q;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pbank[p] = bus.req_addr[p][BSEL-1:0];
      for (int b = 0; b < NUM_BANKS; b++) begin
        hit[p][b] = !rst && bus.req_valid[p]
                    && (pbank[p] == BSEL'(b));
      end
    end
  end

  // pass 0 scans ports at/after the pointer, pass 1 wraps around
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      gvld[b]   = 1'b0;
      gwe[b]    = 1'b0;
      gport[b]  = '0;
      grow[b]   = '0;
      gwdata[b] = '0;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int pz = 0; pz < 2; pz++) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (!gvld[b] && hit[p][b]
              && ((pz == 0) == (PW'(p) >= rr_ptr[b]))) begin
            gvld[b]   = 1'b1;
            gport[b]  = PW'(p);
            gwe[b]    = bus.req_we[p];
            grow[b]   = bus.req_addr[p][ADDR_WID-1:BSEL];
            gwdata[b] = bus.req_wdata[p];
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      ready[p] = (|hit[p]) && (gport[pbank[p]] == PW'(p));
    end
  end

  assign stall         = |(bus.req_valid & ~ready);
  assign bus.req_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (gvld[b]) begin
          rr_ptr[b] <= (gport[b] == PW'(NUM_PORTS - 1))
                       ? '0 : gport[b] + 1'b1;
        end
      end
    end
  end

  // bank arrays and their read registers are never reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (gvld[b]) begin
        if (gwe[b]) mem[b][grow[b]] <= gwdata[b];
        else        rdq[b]          <= mem[b][grow[b]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= '0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) s1_bank[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_vld[p]    <= ready[p] && !bus.req_we[p];
        s1_bank[p]   <= pbank[p];
        rsp_vld_q[p] <= s1_vld[p];
        if (s1_vld[p]) rsp_dat_q[p] <= rdq[s1_bank[p]];
      end
    end
  end

  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rsp_dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_banked_scratchpad.sv
// Directed bench for banked_scratchpad: handshake, arbitration,
// read latency, reset flush and counter saturation.
module tb_banked_scratchpad;
  localparam int NP = 2;
  localparam int NB = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cnt;
  logic [3:0]  cnt4;
  int vec  = 0;
  int miss = 0;

  banked_scratchpad_if #(.NUM_PORTS(NP), .ADDR_WID(AW), .D_WID(DW)) bus ();
  banked_scratchpad_if #(.NUM_PORTS(NP), .ADDR_WID(AW), .D_WID(DW)) bus4 ();

  banked_scratchpad #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WID(AW),
    .D_WID(DW), .CNT_WID(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .conflict_cnt(cnt)
  );

  banked_scratchpad #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WID(AW),
    .D_WID(DW), .CNT_WID(4)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .conflict_cnt(cnt4)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic idle4();
    bus4.req_valid = '0;
    bus4.req_we    = '0;
    bus4.req_addr  = '0;
    bus4.req_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle4();
    bus.req_valid  = 2'b11;
    bus.req_addr[1] = 10'h001;
    bus4.req_valid = 2'b11;
    step();
    step();
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b00) begin
      miss++;
      $display("FAIL rst_ready: got %b want 00", bus.req_ready);
    end
    vec++;
    if (bus4.req_ready !== 2'b00) begin
      miss++;
      $display("FAIL rst_ready4: got %b want 00", bus4.req_ready);
    end
    vec++;
    if (bus.rsp_valid !== 2'b00) begin
      miss++;
      $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid);
    end
    vec++;
    if (bus.rsp_rdata !== '0) begin
      miss++;
      $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata);
    end
    vec++;
    if (cnt !== 16'd0 || cnt4 !== 4'd0) begin
      miss++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", cnt, cnt4);
    end
    step();
    rst = 1'b0;
    idle();
    idle4();
    step();
  endtask

  task automatic test_single();
    idle();
    bus.req_valid[0] = 1'b1;
    bus.req_we[0]    = 1'b1;
    bus.req_addr[0]  = 10'h005;
    bus.req_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b01) begin
      miss++;
      $display("FAIL single_wr_ready: got %b want 01", bus.req_ready);
    end
    step();
    bus.req_we[0] = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b01) begin
      miss++;
      $display("FAIL single_rd_ready: got %b want 01", bus.req_ready);
    end
    step();
    idle();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b00) begin
      miss++;
      $display("FAIL single_early: got %b want 00", bus.rsp_valid);
    end
    step();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b01) begin
      miss++;
      $display("FAIL single_rsp_valid: got %b want 01", bus.rsp_valid);
    end
    vec++;
    if (bus.rsp_rdata[0] !== 32'hDEAD_BEEF) begin
      miss++;
      $display("FAIL single_rdata: got %h want deadbeef",
               bus.rsp_rdata[0]);
    end
    step();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b00 ||
        bus.rsp_rdata[0] !== 32'hDEAD_BEEF) begin
      miss++;
      $display("FAIL single_hold: got %b/%h want 00/deadbeef",
               bus.rsp_valid, bus.rsp_rdata[0]);
    end
    step();
  endtask

  task automatic test_parallel();
    idle();
    bus.req_valid    = 2'b11;
    bus.req_we       = 2'b11;
    bus.req_addr[0]  = 10'h004;
    bus.req_addr[1]  = 10'h001;
    bus.req_wdata[0] = 32'h1111_0004;
    bus.req_wdata[1] = 32'h2222_0001;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b11) begin
      miss++;
      $display("FAIL par_wr_ready: got %b want 11", bus.req_ready);
    end
    step();
    bus.req_we = 2'b00;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b11) begin
      miss++;
      $display("FAIL par_rd_ready: got %b want 11", bus.req_ready);
    end
    step();
    idle();
    step();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b11) begin
      miss++;
      $display("FAIL par_rsp_valid: got %b want 11", bus.rsp_valid);
    end
    vec++;
    if (bus.rsp_rdata[0] !== 32'h1111_0004 ||
        bus.rsp_rdata[1] !== 32'h2222_0001) begin
      miss++;
      $display("FAIL par_rdata: got %h/%h want 11110004/22220001",
               bus.rsp_rdata[0], bus.rsp_rdata[1]);
    end
    vec++;
    if (cnt !== 16'd0) begin
      miss++;
      $display("FAIL par_cnt: got %0d want 0", cnt);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_dat;
    int          pp;
    idle();
    bus.req_valid[0] = 1'b1;
    bus.req_we[0]    = 1'b1;
    bus.req_addr[0]  = 10'h002;
    bus.req_wdata[0] = 32'hB2B2_0002;
    step();
    bus.req_addr[0]  = 10'h006;
    bus.req_wdata[0] = 32'hB6B6_0006;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        bus.req_valid   = 2'b11;
        bus.req_we      = 2'b00;
        bus.req_addr[0] = 10'h002;
        bus.req_addr[1] = 10'h006;
      end else begin
        idle();
      end
      @(negedge clk);
      if (c < 4) begin
        exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
        vec++;
        if (bus.req_ready !== exp_rdy) begin
          miss++;
          $display("FAIL rr_grant c%0d: got %b want %b",
                   c, bus.req_ready, exp_rdy);
        end
      end
      exp_rsp = 2'b00;
      if (c >= 2) exp_rsp = ((c - 2) % 2 == 0) ? 2'b01 : 2'b10;
      vec++;
      if (bus.rsp_valid !== exp_rsp) begin
        miss++;
        $display("FAIL rr_rsp c%0d: got %b want %b",
                 c, bus.rsp_valid, exp_rsp);
      end
      if (c >= 2) begin
        pp      = (c - 2) % 2;
        exp_dat = (pp == 0) ? 32'hB2B2_0002 : 32'hB6B6_0006;
        vec++;
        if (bus.rsp_rdata[pp] !== exp_dat) begin
          miss++;
          $display("FAIL rr_rdata c%0d: got %h want %h",
                   c, bus.rsp_rdata[pp], exp_dat);
        end
      end
      if (c >= 4) begin
        vec++;
        if (cnt !== 16'd4) begin
          miss++;
          $display("FAIL rr_cnt c%0d: got %0d want 4", c, cnt);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 10'h005;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b01) begin
      miss++;
      $display("FAIL mid_ready: got %b want 01", bus.req_ready);
    end
    step();
    idle();
    rst = 1'b1;
    bus.req_valid[1] = 1'b1;
    bus.req_addr[1]  = 10'h003;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
      miss++;
      $display("FAIL mid_in_rst: got rdy %b rsp %b want 00/00",
               bus.req_ready, bus.rsp_valid);
    end
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b00) begin
      miss++;
      $display("FAIL mid_t2: got %b want 00", bus.rsp_valid);
    end
    vec++;
    if (cnt !== 16'd0 || bus.rsp_rdata !== '0) begin
      miss++;
      $display("FAIL mid_clear: got cnt %0d rdata %h want 0/0",
               cnt, bus.rsp_rdata);
    end
    step();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b00) begin
      miss++;
      $display("FAIL mid_t3: got %b want 00", bus.rsp_valid);
    end
    step();
    bus.req_valid[0] = 1'b1;
    bus.req_addr[0]  = 10'h005;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b01) begin
      miss++;
      $display("FAIL mid_post_ready: got %b want 01", bus.req_ready);
    end
    step();
    idle();
    step();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b01 ||
        bus.rsp_rdata[0] !== 32'hDEAD_BEEF) begin
      miss++;
      $display("FAIL mid_post_rsp: got %b/%h want 01/deadbeef",
               bus.rsp_valid, bus.rsp_rdata[0]);
    end
    step();
  endtask

  task automatic test_stream();
    int          acc;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_dat;
    acc = 0;
    idle();
    for (int i = 0; i < 16; i++) begin
      bus.req_valid[0] = 1'b1;
      bus.req_we[0]    = 1'b1;
      bus.req_addr[0]  = AW'(i);
      bus.req_wdata[0] = 32'hC0DE_0000 + 32'(i);
      step();
    end
    idle();
    for (int c = 0; c < 19; c++) begin
      if (c < 16) begin
        bus.req_valid[0] = 1'b1;
        bus.req_we[0]    = 1'b0;
        bus.req_addr[0]  = AW'(c);
      end else begin
        idle();
      end
      @(negedge clk);
      if (c < 16 && bus.req_ready[0] === 1'b1) acc++;
      exp_rsp = (c >= 2 && c < 18) ? 2'b01 : 2'b00;
      vec++;
      if (bus.rsp_valid !== exp_rsp) begin
        miss++;
        $display("FAIL stream_rsp c%0d: got %b want %b",
                 c, bus.rsp_valid, exp_rsp);
      end
      if (c >= 2 && c < 18) begin
        exp_dat = 32'hC0DE_0000 + 32'(c - 2);
        if (bus.rsp_rdata[0] !== exp_dat) begin
          vec++;
          miss++;
          $display("FAIL stream_rdata c%0d: got %h want %h",
                   c, bus.rsp_rdata[0], exp_dat);
        end
      end
      step();
    end
    vec++;
    if (acc != 16) begin
      miss++;
      $display("FAIL stream_accepts: got %0d want 16", acc);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    bus.req_valid[0] = 1'b1;
    bus.req_we[0]    = 1'b1;
    bus.req_addr[0]  = 10'h00A;
    bus.req_wdata[0] = 32'h1234_5678;
    step();
    idle();
    bus.req_valid[1] = 1'b1;
    bus.req_addr[1]  = 10'h00A;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b10) begin
      miss++;
      $display("FAIL b2b_rd_ready: got %b want 10", bus.req_ready);
    end
    step();
    idle();
    step();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b10 ||
        bus.rsp_rdata[1] !== 32'h1234_5678) begin
      miss++;
      $display("FAIL b2b_raw: got %b/%h want 10/12345678",
               bus.rsp_valid, bus.rsp_rdata[1]);
    end
    step();
    // same-address write and read collide: port0 holds the pointer
    bus.req_valid    = 2'b11;
    bus.req_we       = 2'b01;
    bus.req_addr[0]  = 10'h00A;
    bus.req_addr[1]  = 10'h00A;
    bus.req_wdata[0] = 32'hAAAA_5555;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b01) begin
      miss++;
      $display("FAIL b2b_coll_ready: got %b want 01", bus.req_ready);
    end
    step();
    bus.req_valid[0] = 1'b0;
    bus.req_we[0]    = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 2'b10) begin
      miss++;
      $display("FAIL b2b_coll_retry: got %b want 10", bus.req_ready);
    end
    step();
    idle();
    step();
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 2'b10 ||
        bus.rsp_rdata[1] !== 32'hAAAA_5555) begin
      miss++;
      $display("FAIL b2b_coll_rsp: got %b/%h want 10/aaaa5555",
               bus.rsp_valid, bus.rsp_rdata[1]);
    end
    vec++;
    if (cnt !== 16'd1) begin
      miss++;
      $display("FAIL b2b_cnt: got %0d want 1", cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    idle4();
    for (int c = 0; c < 20; c++) begin
      bus4.req_valid   = 2'b11;
      bus4.req_addr[0] = 10'h000;
      bus4.req_addr[1] = 10'h004;
      @(negedge clk);
      exp_cnt = (c > 15) ? 4'd15 : 4'(c);
      vec++;
      if (cnt4 !== exp_cnt) begin
        miss++;
        $display("FAIL sat_cnt c%0d: got %0d want %0d",
                 c, cnt4, exp_cnt);
      end
      step();
    end
    idle4();
    step();
    @(negedge clk);
    vec++;
    if (cnt4 !== 4'd15) begin
      miss++;
      $display("FAIL sat_hold: got %0d want 15", cnt4);
    end
    step();
  endtask

  initial begin
    idle();
    idle4();
    #1;
    test_reset();
    test_single();
    test_parallel();
    test_round_robin();
    test_reset_midflight();
    test_stream();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
